// File: rtl/sram_port_arbiter.sv
// Two-port round-robin front end for the 16-bit SRAM controller: latches one
// 32-bit request, holds the controller enables until Ready (or a watchdog abort), then acks.
module sram_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;

    logic               any_req;
    logic               win;
    logic               in_access;
    logic               in_ack;

    // On a tie the port that did not own the previous transfer wins.
    assign any_req = p0_req | p1_req;
    assign win     = (p0_req & p1_req) ? ~last_q : p1_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = win;
                    we_d    = win ? p1_we    : p0_we;
                    addr_d  = win ? p1_addr  : p0_addr;
                    wdata_d = win ? p1_wdata : p0_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ready beats the watchdog when both land in the same cycle.
                if (mem_ready) begin
                    if (owner_q) rdata1_d = mem_rdata;
                    else         rdata0_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_ACK;
                end else if (cnt_q == CNT_LAST) begin
                    if (owner_q) rdata1_d = '0;
                    else         rdata0_d = '0;
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_access = (state_q == S_ACCESS);
    assign in_ack    = (state_q == S_ACK);

    // Enables drop in ACK so the controller settles back to idle before the next transfer.
    assign mem_w_en  = in_access & we_q;
    assign mem_r_en  = in_access & ~we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign busy      = (state_q != S_IDLE);
    assign grant     = busy ? {owner_q, ~owner_q} : 2'b00;

    assign p0_ack    = in_ack & ~owner_q;
    assign p1_ack    = in_ack & owner_q;
    assign p0_err    = p0_ack & err_q;
    assign p1_err    = p1_ack & err_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 16-bit SRAM controller
// whose Ready rises on the sixth enabled cycle.
module tb_sram_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_ack, p0_err, p1_ack, p1_err;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              mem_w_en, mem_r_en, mem_ready, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [1:0]        grant;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    // Controller model: halfword memory, Ready on the sixth consecutive enabled cycle.
    logic [15:0] mem [0:255];
    logic [7:0]  mcnt;
    logic        ready_kill;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic [7:0]  ma, ma1;
    logic        en;

    assign en        = mem_w_en | mem_r_en;
    assign ma        = mem_addr[7:0];
    assign ma1       = mem_addr[7:0] + 8'd1;
    assign mem_ready = en && !ready_kill && (mcnt == 8'd5);
    assign mem_rdata = {mem[ma1], mem[ma]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     mcnt <= 8'd0;
        else if (en) mcnt <= mcnt + 8'd1;
        else         mcnt <= 8'd0;
    end

    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        if (mem_w_en && mem_ready) begin
            mem[ma]  <= mem_wdata[15:0];
            mem[ma1] <= mem_wdata[31:16];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int t_ack, t_ack2, n_ren, n_wen_ok, n_other, idle_cnt, acks, dbl, nt;
    logic [DATA_W-1:0] rd;
    logic er, prev_ack;
    logic [1:0] prev_g, first_g;
    logic [1:0] seq [0:3];

    initial begin
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        ready_kill = 0; load_en = 0; load_addr = '0; load_data = '0;
        tick();
        load(8'h10, 16'hBEEF);
        load(8'h11, 16'hDEAD);
        load(8'h30, 16'h0BAD);

        // Reset state
        check("rst_ctrl", 32'({mem_w_en, mem_r_en, busy, grant, p0_ack, p1_ack, p0_err, p1_err}), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata0", p0_rdata, 32'd0);
        check("rst_rdata1", p1_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // p0 read of 0x10
        p0_we = 0; p0_addr = 32'h10; p0_req = 1;
        t_ack = 0; n_ren = 0; n_other = 0; rd = '0; er = 1'bx;
        for (int t = 1; t <= 12 && t_ack == 0; t++) begin
            tick();
            if (mem_r_en) n_ren++;
            if (p1_ack) n_other++;
            if (p0_ack) begin t_ack = t; rd = p0_rdata; er = p0_err; p0_req = 0; end
        end
        check("rd_ack_cycle", 32'(t_ack), 32'd7);
        check("rd_rdata", rd, 32'hDEADBEEF);
        check("rd_err", 32'(er), 32'd0);
        check("rd_ren_cycles", 32'(n_ren), 32'd6);
        check("rd_p1_ack", 32'(n_other), 32'd0);
        tick();
        check("rd_ack_single", 32'({p0_ack, busy}), 32'd0);

        // p1 write of 0x12345678 to 0x20
        p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h12345678; p1_req = 1;
        t_ack = 0; n_ren = 0; n_wen_ok = 0; n_other = 0; er = 1'bx;
        for (int t = 1; t <= 12 && t_ack == 0; t++) begin
            tick();
            if (mem_r_en) n_ren++;
            if (mem_w_en && mem_addr == 32'h20 && mem_wdata == 32'h12345678) n_wen_ok++;
            if (p0_ack) n_other++;
            if (p1_ack) begin t_ack = t; er = p1_err; p1_req = 0; end
        end
        check("wr_ack_cycle", 32'(t_ack), 32'd7);
        check("wr_wen_cycles", 32'(n_wen_ok), 32'd6);
        check("wr_ren_cycles", 32'(n_ren), 32'd0);
        check("wr_err", 32'(er), 32'd0);
        check("wr_p0_ack", 32'(n_other), 32'd0);
        tick();
        check("wr_mem_lo", 32'(mem[8'h20]), 32'h5678);
        check("wr_mem_hi", 32'(mem[8'h21]), 32'h1234);

        // Both ports held high: round-robin alternation
        p0_we = 0; p0_addr = 32'h10; p1_we = 0; p1_addr = 32'h20;
        p0_req = 1; p1_req = 1;
        acks = 0; dbl = 0; idle_cnt = 0; nt = 0; prev_ack = 0; prev_g = 2'b00; t_ack = 0;
        for (int i = 0; i < 4; i++) seq[i] = 2'b11;
        for (int t = 1; t <= 40 && acks < 4; t++) begin
            tick();
            if (grant != 2'b00 && prev_g == 2'b00 && nt < 4) begin seq[nt] = grant; nt++; end
            if (grant == 2'b00) idle_cnt++;
            if (p0_ack || p1_ack) begin
                acks++;
                if (prev_ack) dbl++;
            end
            prev_ack = p0_ack | p1_ack;
            prev_g = grant;
            if (acks == 4) begin p0_req = 0; p1_req = 0; t_ack = t; end
        end
        check("rr_acks", 32'(acks), 32'd4);
        check("rr_grant0", 32'(seq[0]), 32'b01);
        check("rr_grant1", 32'(seq[1]), 32'b10);
        check("rr_grant2", 32'(seq[2]), 32'b01);
        check("rr_grant3", 32'(seq[3]), 32'b10);
        check("rr_double_ack", 32'(dbl), 32'd0);
        check("rr_idle_gaps", 32'(idle_cnt), 32'd3);
        check("rr_last_ack_cycle", 32'(t_ack), 32'd31);
        check("rr_rdata0", p0_rdata, 32'hDEADBEEF);
        check("rr_rdata1", p1_rdata, 32'h12345678);
        tick();
        check("rr_idle_after", 32'(busy), 32'd0);

        // Ready stuck low: watchdog abort, then queued p1 served
        ready_kill = 1;
        p0_req = 1; p1_req = 1;
        t_ack = 0; n_ren = 0; n_other = 0; rd = 'x; er = 1'bx; first_g = 2'b11;
        for (int t = 1; t <= 30 && t_ack == 0; t++) begin
            tick();
            if (t == 1) first_g = grant;
            if (mem_r_en) n_ren++;
            if (p1_ack) n_other++;
            if (p0_ack) begin
                t_ack = t; rd = p0_rdata; er = p0_err;
                p0_req = 0; ready_kill = 0;
            end
        end
        check("to_grant", 32'(first_g), 32'b01);
        check("to_ack_cycle", 32'(t_ack), 32'd17);
        check("to_ren_cycles", 32'(n_ren), 32'd16);
        check("to_err", 32'(er), 32'd1);
        check("to_rdata", rd, 32'd0);
        check("to_p1_ack", 32'(n_other), 32'd0);
        t_ack2 = 0; er = 1'bx;
        for (int t = 1; t <= 12 && t_ack2 == 0; t++) begin
            tick();
            if (p1_ack) begin t_ack2 = t; er = p1_err; rd = p1_rdata; p1_req = 0; end
        end
        check("to_p1_ack_cycle", 32'(t_ack2), 32'd8);
        check("to_p1_err", 32'(er), 32'd0);
        check("to_p1_rdata", rd, 32'h12345678);
        check("to_p0_rdata_hold", p0_rdata, 32'd0);
        tick();

        // Asynchronous reset during ACCESS cycle 3 of a p1 write
        p1_we = 1; p1_addr = 32'h30; p1_wdata = 32'hAAAA5555; p1_req = 1;
        tick(); tick(); tick();
        check("rst_pre_wen", 32'({mem_w_en, grant}), 32'b110);
        #2 rst = 1'b1;
        #1;
        check("arst_ctrl", 32'({mem_w_en, mem_r_en, busy, grant, p0_ack, p1_ack, p0_err, p1_err}), 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_wdata", mem_wdata, 32'd0);
        check("arst_rdata1", p1_rdata, 32'd0);
        p0_we = 0; p0_addr = 32'h10; p0_req = 1;
        p1_we = 0; p1_addr = 32'h20;
        tick(); tick();
        check("arst_mem_untouched", 32'(mem[8'h30]), 32'h0BAD);
        rst = 1'b0;
        t_ack = 0; n_other = 0; first_g = 2'b11; rd = 'x;
        for (int t = 1; t <= 12 && t_ack == 0; t++) begin
            tick();
            if (t == 1) first_g = grant;
            if (p1_ack) n_other++;
            if (p0_ack) begin t_ack = t; rd = p0_rdata; p0_req = 0; end
        end
        check("post_rst_grant", 32'(first_g), 32'b01);
        check("post_rst_p0_ack", 32'(t_ack), 32'd7);
        check("post_rst_p0_rdata", rd, 32'hDEADBEEF);
        check("post_rst_no_p1_ack", 32'(n_other), 32'd0);
        t_ack2 = 0;
        for (int t = 1; t <= 12 && t_ack2 == 0; t++) begin
            tick();
            if (p1_ack) begin t_ack2 = t; rd = p1_rdata; p1_req = 0; end
        end
        check("post_rst_p1_ack", 32'(t_ack2), 32'd8);
        check("post_rst_p1_rdata", rd, 32'h12345678);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
